// File: rtl/multicycle_control.sv
// Sequencer for the multicycle MIPS datapath: FETCH/DECODE/EXEC/MEM/WB FSM with a mul/div wait
// counter. Decode fields are captured on DECODE exit; strobes are decoded from state each cycle.
module multicycle_control #(
  parameter int unsigned MultCycles = 4,
  parameter int unsigned DivCycles  = 32,
  parameter int unsigned CntW       = 6
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] function_code_i,
  input  logic [4:0] b_code_i,
  input  logic       waitrequest_i,
  input  logic       pc_is_zero_i,
  output logic       active_o,
  output logic [2:0] state_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_wren_o,
  output logic       pc_wren_o,
  output logic       reg_write_o,
  output logic       hi_wren_o,
  output logic       lo_wren_o,
  output logic       rd_select_o,
  output logic       imdt_sel_o,
  output logic       branch_o,
  output logic       jump_o,
  output logic       alu_src_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] data_into_reg_o
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StMulDiv = 3'd5,
    StHalt   = 3'd6
  } state_e;

  // ClsJump covers everything that retires in EXEC with a PC update (branches, J, JR).
  typedef enum logic [3:0] {
    ClsNop, ClsJump, ClsWb, ClsLoad, ClsStore, ClsMult, ClsDiv, ClsMthi, ClsMtlo
  } cls_e;

  state_e          state_q;
  cls_e            cls_q, cls_d;
  logic [CntW-1:0] cnt_q;
  logic            rd_select_q, rd_select_d;
  logic            imdt_sel_q, imdt_sel_d;
  logic            branch_q, branch_d;
  logic            jump_q, jump_d;
  logic            alu_src_q, alu_src_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic [1:0]      data_into_reg_q, data_into_reg_d;

  always_comb begin
    cls_d           = ClsNop;
    rd_select_d     = 1'b0;
    imdt_sel_d      = 1'b0;
    branch_d        = 1'b0;
    jump_d          = 1'b0;
    alu_src_d       = 1'b0;
    alu_op_d        = 2'd0;
    data_into_reg_d = 2'd0;
    if (opcode_i == 6'd0) begin
      if (function_code_i == 6'd8) begin
        cls_d  = ClsJump;
        jump_d = 1'b1;
      end else if (function_code_i == 6'd9) begin
        cls_d           = ClsWb;
        jump_d          = 1'b1;
        rd_select_d     = 1'b1;
        data_into_reg_d = 2'd2;
      end else if (function_code_i == 6'd17) begin
        cls_d = ClsMthi;
      end else if (function_code_i == 6'd19) begin
        cls_d = ClsMtlo;
      end else if (function_code_i inside {6'd24, 6'd25}) begin
        cls_d = ClsMult;
      end else if (function_code_i inside {6'd26, 6'd27}) begin
        cls_d = ClsDiv;
      end else if (function_code_i inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd16, 6'd18,
                                           [6'd32:6'd39], 6'd42, 6'd43}) begin
        cls_d       = ClsWb;
        rd_select_d = 1'b1;
        alu_op_d    = 2'd2;
      end
    end else if (opcode_i == 6'd1) begin
      if (b_code_i inside {5'd0, 5'd1}) begin
        cls_d    = ClsJump;
        branch_d = 1'b1;
        alu_op_d = 2'd1;
      end else if (b_code_i inside {5'd16, 5'd17}) begin
        cls_d           = ClsWb;
        branch_d        = 1'b1;
        alu_op_d        = 2'd1;
        data_into_reg_d = 2'd2;
      end
    end else if (opcode_i == 6'd2) begin
      cls_d  = ClsJump;
      jump_d = 1'b1;
    end else if (opcode_i == 6'd3) begin
      cls_d           = ClsWb;
      jump_d          = 1'b1;
      data_into_reg_d = 2'd2;
    end else if (opcode_i inside {[6'd4:6'd7]}) begin
      cls_d    = ClsJump;
      branch_d = 1'b1;
      alu_op_d = 2'd1;
    end else if (opcode_i inside {[6'd9:6'd15]}) begin
      cls_d      = ClsWb;
      alu_src_d  = 1'b1;
      alu_op_d   = 2'd3;
      imdt_sel_d = (opcode_i inside {[6'd12:6'd14]});  // ANDI/ORI/XORI zero-extend
    end else if (opcode_i inside {[6'd32:6'd38]}) begin
      cls_d           = ClsLoad;
      alu_src_d       = 1'b1;
      data_into_reg_d = 2'd1;
    end else if (opcode_i inside {6'd40, 6'd41, 6'd43}) begin
      cls_d     = ClsStore;
      alu_src_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= StFetch;
      cls_q           <= ClsNop;
      cnt_q           <= '0;
      rd_select_q     <= 1'b0;
      imdt_sel_q      <= 1'b0;
      branch_q        <= 1'b0;
      jump_q          <= 1'b0;
      alu_src_q       <= 1'b0;
      alu_op_q        <= 2'd0;
      data_into_reg_q <= 2'd0;
    end else begin
      case (state_q)
        StFetch: begin
          if (pc_is_zero_i)        state_q <= StHalt;
          else if (!waitrequest_i) state_q <= StDecode;
        end
        StDecode: begin
          cls_q           <= cls_d;
          rd_select_q     <= rd_select_d;
          imdt_sel_q      <= imdt_sel_d;
          branch_q        <= branch_d;
          jump_q          <= jump_d;
          alu_src_q       <= alu_src_d;
          alu_op_q        <= alu_op_d;
          data_into_reg_q <= data_into_reg_d;
          state_q         <= StExec;
        end
        StExec: begin
          case (cls_q)
            ClsWb:             state_q <= StWb;
            ClsLoad, ClsStore: state_q <= StMem;
            ClsMult: begin
              cnt_q   <= CntW'(MultCycles - 1);
              state_q <= StMulDiv;
            end
            ClsDiv: begin
              cnt_q   <= CntW'(DivCycles - 1);
              state_q <= StMulDiv;
            end
            default:           state_q <= StFetch;
          endcase
        end
        StMem: begin
          if (!waitrequest_i) state_q <= (cls_q == ClsLoad) ? StWb : StFetch;
        end
        StWb: state_q <= StFetch;
        StMulDiv: begin
          if (cnt_q == '0) state_q <= StFetch;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StFetch;
      endcase
    end
  end

  // Strobes are forced low while reset is asserted so an aborted instruction commits nothing.
  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    ir_wren_o   = 1'b0;
    pc_wren_o   = 1'b0;
    reg_write_o = 1'b0;
    hi_wren_o   = 1'b0;
    lo_wren_o   = 1'b0;
    if (!reset_i) begin
      case (state_q)
        StFetch: begin
          if (!pc_is_zero_i) begin
            mem_read_o = 1'b1;
            ir_wren_o  = !waitrequest_i;
          end
        end
        StExec: begin
          case (cls_q)
            ClsNop, ClsJump: pc_wren_o = 1'b1;
            ClsMthi: begin
              pc_wren_o = 1'b1;
              hi_wren_o = 1'b1;
            end
            ClsMtlo: begin
              pc_wren_o = 1'b1;
              lo_wren_o = 1'b1;
            end
            default: ;
          endcase
        end
        StMem: begin
          if (cls_q == ClsStore) begin
            mem_write_o = 1'b1;
            pc_wren_o   = !waitrequest_i;
          end else begin
            mem_read_o = 1'b1;
          end
        end
        StWb: begin
          reg_write_o = 1'b1;
          pc_wren_o   = 1'b1;
        end
        StMulDiv: begin
          if (cnt_q == '0) begin
            hi_wren_o = 1'b1;
            lo_wren_o = 1'b1;
            pc_wren_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign active_o        = reset_i || (state_q != StHalt);
  assign state_o         = state_q;
  assign rd_select_o     = rd_select_q;
  assign imdt_sel_o      = imdt_sel_q;
  assign branch_o        = branch_q;
  assign jump_o          = jump_q;
  assign alu_src_o       = alu_src_q;
  assign alu_op_o        = alu_op_q;
  assign data_into_reg_o = data_into_reg_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks ALU, load, store, mul/div, jump, link-branch,
// MTHI and halt sequences, checking state, strobes and decode fields cycle by cycle.
module tb_multicycle_control;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [5:0] opcode_i;
  logic [5:0] function_code_i;
  logic [4:0] b_code_i;
  logic       waitrequest_i;
  logic       pc_is_zero_i;
  logic       active_o;
  logic [2:0] state_o;
  logic       mem_read_o, mem_write_o, ir_wren_o, pc_wren_o, reg_write_o, hi_wren_o, lo_wren_o;
  logic       rd_select_o, imdt_sel_o, branch_o, jump_o, alu_src_o;
  logic [1:0] alu_op_o, data_into_reg_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Strobe bundle order: {mem_read, mem_write, ir_wren, pc_wren, reg_write, hi_wren, lo_wren}
  logic [6:0] strb;
  assign strb = {mem_read_o, mem_write_o, ir_wren_o, pc_wren_o, reg_write_o, hi_wren_o, lo_wren_o};

  always #5 clk_i = ~clk_i;

  multicycle_control #(
    .MultCycles(4),
    .DivCycles (32),
    .CntW      (6)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .opcode_i       (opcode_i),
    .function_code_i(function_code_i),
    .b_code_i       (b_code_i),
    .waitrequest_i  (waitrequest_i),
    .pc_is_zero_i   (pc_is_zero_i),
    .active_o       (active_o),
    .state_o        (state_o),
    .mem_read_o     (mem_read_o),
    .mem_write_o    (mem_write_o),
    .ir_wren_o      (ir_wren_o),
    .pc_wren_o      (pc_wren_o),
    .reg_write_o    (reg_write_o),
    .hi_wren_o      (hi_wren_o),
    .lo_wren_o      (lo_wren_o),
    .rd_select_o    (rd_select_o),
    .imdt_sel_o     (imdt_sel_o),
    .branch_o       (branch_o),
    .jump_o         (jump_o),
    .alu_src_o      (alu_src_o),
    .alu_op_o       (alu_op_o),
    .data_into_reg_o(data_into_reg_o)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  // Runs FETCH and DECODE for one instruction, then leaves the bench in the EXEC cycle.
  task automatic fetch_dec(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] bc);
    opcode_i        = op;
    function_code_i = fn;
    b_code_i        = bc;
    waitrequest_i   = 1'b0;
    #1;
    check("fetch_state", state_o, 0);
    check("fetch_strb", strb, 7'b1010000);
    step();
    check("decode_state", state_o, 1);
    check("decode_strb", strb, 7'b0000000);
    step();
    opcode_i        = 6'h3f;  // decode fields must hold after DECODE
    function_code_i = 6'h3f;
    #1;
    check("exec_state", state_o, 2);
  endtask

  initial begin
    reset_i         = 1'b1;
    opcode_i        = '0;
    function_code_i = '0;
    b_code_i        = '0;
    waitrequest_i   = 1'b0;
    pc_is_zero_i    = 1'b0;
    step();
    check("rst_state", state_o, 0);
    check("rst_active", active_o, 1);
    check("rst_strb", strb, 7'b0000000);
    check("rst_fields", {rd_select_o, imdt_sel_o, branch_o, jump_o, alu_src_o, alu_op_o,
                         data_into_reg_o}, 0);
    step();
    reset_i = 1'b0;

    // ADDU
    fetch_dec(6'd0, 6'd33, 5'd0);
    check("addu_exec_strb", strb, 7'b0000000);
    check("addu_alu_op", alu_op_o, 2);
    check("addu_rd_sel", rd_select_o, 1);
    step();
    check("addu_wb_state", state_o, 4);
    check("addu_wb_strb", strb, 7'b0001100);
    check("addu_dir", data_into_reg_o, 0);
    step();

    // LW with a one-cycle fetch stall and two MEM stall cycles
    waitrequest_i = 1'b1;
    #1;
    check("fstall_state", state_o, 0);
    check("fstall_strb", strb, 7'b1000000);
    step();
    fetch_dec(6'd35, 6'd0, 5'd0);
    check("lw_exec_strb", strb, 7'b0000000);
    check("lw_alu", {alu_src_o, alu_op_o}, 3'b100);
    waitrequest_i = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      check("lw_mem_stall_state", state_o, 3);
      check("lw_mem_stall_strb", strb, 7'b1000000);
      step();
    end
    waitrequest_i = 1'b0;
    #1;
    check("lw_mem_done_strb", strb, 7'b1000000);
    step();
    check("lw_wb_state", state_o, 4);
    check("lw_wb_strb", strb, 7'b0001100);
    check("lw_dir", data_into_reg_o, 1);
    step();

    // MULT: four MULDIV cycles, write on the last
    fetch_dec(6'd0, 6'd24, 5'd0);
    check("mult_exec_strb", strb, 7'b0000000);
    step();
    for (int i = 0; i < 3; i++) begin
      check("mult_wait_state", state_o, 5);
      check("mult_wait_strb", strb, 7'b0000000);
      step();
    end
    check("mult_last_state", state_o, 5);
    check("mult_last_strb", strb, 7'b0001011);
    step();
    check("mult_after_state", state_o, 0);

    // DIV aborted by reset in the 10th MULDIV cycle
    fetch_dec(6'd0, 6'd26, 5'd0);
    step();
    for (int i = 0; i < 9; i++) begin
      check("div_wait_state", state_o, 5);
      check("div_wait_strb", strb, 7'b0000000);
      step();
    end
    reset_i = 1'b1;
    #1;
    check("div_abort_strb", strb, 7'b0000000);
    step();
    check("div_abort_state", state_o, 0);
    reset_i = 1'b0;

    // SW with five MEM stall cycles
    fetch_dec(6'd43, 6'd0, 5'd0);
    check("sw_alu", {alu_src_o, alu_op_o, data_into_reg_o}, 5'b10000);
    waitrequest_i = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      check("sw_stall_state", state_o, 3);
      check("sw_stall_strb", strb, 7'b0100000);
      step();
    end
    waitrequest_i = 1'b0;
    #1;
    check("sw_done_strb", strb, 7'b0101000);
    step();
    check("sw_after_state", state_o, 0);

    // MTHI retires in EXEC
    fetch_dec(6'd0, 6'd17, 5'd0);
    check("mthi_strb", strb, 7'b0001010);
    step();
    check("mthi_after_state", state_o, 0);

    // BLTZAL links through WB
    fetch_dec(6'd1, 6'd0, 5'd16);
    check("bltzal_fields", {branch_o, jump_o, alu_op_o, data_into_reg_o}, 6'b100110);
    check("bltzal_exec_strb", strb, 7'b0000000);
    step();
    check("bltzal_wb_state", state_o, 4);
    check("bltzal_wb_strb", strb, 7'b0001100);
    step();

    // J retires in EXEC
    fetch_dec(6'd2, 6'd0, 5'd0);
    check("j_fields", {branch_o, jump_o, data_into_reg_o}, 4'b0100);
    check("j_strb", strb, 7'b0001000);
    step();
    check("j_after_state", state_o, 0);

    // Halt on PC == 0
    pc_is_zero_i  = 1'b1;
    waitrequest_i = 1'b0;
    #1;
    check("halt_fetch_strb", strb, 7'b0000000);
    step();
    pc_is_zero_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("halt_state", state_o, 6);
      check("halt_active", active_o, 0);
      check("halt_strb", strb, 7'b0000000);
      step();
    end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    #1;
    check("halt_reset_state", state_o, 0);
    check("halt_reset_active", active_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
